mips_cpu_bus_arbiter: RTL and testbench

// Single Avalon-MM master port shared by the CPU's instruction-fetch and data (load/store) requesters.
// - Arbitrates between the two requesters and sequences each bus transaction through waitrequest stalls.
// - Steers byte lanes and byteenable for byte/half/word accesses; sign- or zero-extends load data.
// - Sits between the multicycle control FSM and the external memory bus; the CPU core never drives the bus directly.

---
 rtl/mips_cpu_bus_arbiter_if.sv | 37 +++
 rtl/mips_cpu_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_arbiter_if.sv
// mips_cpu_bus_arbiter_if: fetch/data requester ports and Avalon-MM master bus of the CPU bus arbiter
interface mips_cpu_bus_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_signed;
    logic [31:0] data_wdata;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        busy;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    modport master (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_size, data_signed,
               data_wdata, waitrequest, readdata,
        output fetch_done, fetch_instr, fetch_err, data_done, data_rdata, data_err, busy,
               address, read, write, writedata, byteenable
    );
    modport slave (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_size, data_signed,
               data_wdata, waitrequest, readdata,
        input  fetch_done, fetch_instr, fetch_err, data_done, data_rdata, data_err, busy,
               address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: shares one Avalon-MM master between instruction fetch and data load/store
module mips_cpu_bus_arbiter #(
    parameter int TIMEOUT = 0
) (
    input logic clk,
    input logic reset,
    mips_cpu_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_CAPTURE} state_t;
    state_t      state;
    logic [31:0] count;
    logic        is_data;
    logic        is_we;
    logic        is_signed;
    logic [1:0]  sz;
    logic [1:0]  ofs;
    logic        take_data;
    logic        take_fetch;
    logic [31:0] g_addr;
    logic [1:0]  g_size;
    logic        g_mis;
    logic [3:0]  g_be;
    logic [31:0] g_wd;
    logic [31:0] sh;
    logic [31:0] ext;
    logic        timed_out;
    // A requester whose done pulse is still high has already been served this cycle
    assign take_data  = bus.data_req && !bus.data_done;
    assign take_fetch = bus.fetch_req && !bus.fetch_done && !take_data;
    assign g_addr     = take_data ? bus.data_addr : bus.fetch_addr;
    assign g_size     = take_data ? bus.data_size : 2'b10;
    assign g_mis      = (g_size == 2'b11) || (g_size == 2'b01 && g_addr[0]) ||
                        (g_size == 2'b10 && g_addr[1:0] != 2'b00);
    assign g_be       = g_size == 2'b00 ? 4'b0001 << g_addr[1:0] :
                        g_size == 2'b01 ? (g_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign g_wd       = g_size == 2'b00 ? {4{bus.data_wdata[7:0]}} :
                        g_size == 2'b01 ? {2{bus.data_wdata[15:0]}} : bus.data_wdata;
    assign sh         = bus.readdata >> {ofs, 3'b000};
    assign ext        = sz == 2'b00 ? {{24{is_signed & sh[7]}}, sh[7:0]} :
                        sz == 2'b01 ? {{16{is_signed & sh[15]}}, sh[15:0]} : bus.readdata;
    assign timed_out  = (TIMEOUT != 0) && (count == 32'(TIMEOUT - 1));
    // Transaction sequencer; every bus and requester output is registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            count           <= '0;
            is_data         <= 1'b0;
            is_we           <= 1'b0;
            is_signed       <= 1'b0;
            sz              <= 2'b00;
            ofs             <= 2'b00;
            bus.fetch_done  <= 1'b0;
            bus.fetch_instr <= '0;
            bus.fetch_err   <= 1'b0;
            bus.data_done   <= 1'b0;
            bus.data_rdata  <= '0;
            bus.data_err    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.address     <= '0;
            bus.read        <= 1'b0;
            bus.write       <= 1'b0;
            bus.writedata   <= '0;
            bus.byteenable  <= 4'b0000;
        end else begin
            bus.fetch_done <= 1'b0;
            bus.fetch_err  <= 1'b0;
            bus.data_done  <= 1'b0;
            bus.data_err   <= 1'b0;
            case (state)
                S_IDLE: if (take_data || take_fetch) begin
                    is_data   <= take_data;
                    is_we     <= take_data && bus.data_we;
                    is_signed <= take_data && bus.data_signed;
                    sz        <= g_size;
                    ofs       <= g_addr[1:0];
                    if (g_mis) begin
                        bus.data_done  <= take_data;
                        bus.data_err   <= take_data;
                        bus.fetch_done <= !take_data;
                        bus.fetch_err  <= !take_data;
                    end else begin
                        state          <= S_BUS;
                        bus.busy       <= 1'b1;
                        bus.address    <= {g_addr[31:2], 2'b00};
                        bus.byteenable <= g_be;
                        bus.writedata  <= g_wd;
                        bus.read       <= !(take_data && bus.data_we);
                        bus.write      <= take_data && bus.data_we;
                    end
                end
                S_BUS: if (!bus.waitrequest) begin
                    count     <= '0;
                    bus.read  <= 1'b0;
                    bus.write <= 1'b0;
                    if (is_we) begin
                        state         <= S_IDLE;
                        bus.busy      <= 1'b0;
                        bus.data_done <= 1'b1;
                    end else begin
                        state <= S_CAPTURE;
                    end
                end else if (timed_out) begin
                    count          <= '0;
                    bus.read       <= 1'b0;
                    bus.write      <= 1'b0;
                    state          <= S_IDLE;
                    bus.busy       <= 1'b0;
                    bus.data_done  <= is_data;
                    bus.data_err   <= is_data;
                    bus.fetch_done <= !is_data;
                    bus.fetch_err  <= !is_data;
                end else begin
                    count <= count + 32'd1;
                end
                S_CAPTURE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    if (is_data) begin
                        bus.data_rdata <= ext;
                        bus.data_done  <= 1'b1;
                    end else begin
                        bus.fetch_instr <= ext;
                        bus.fetch_done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter: directed checks of arbitration, lane steering, extension, errors and timeout
module tb_mips_cpu_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    mips_cpu_bus_arbiter_if b();
    mips_cpu_bus_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(b));
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic sg,
                        input logic [31:0] rd, input logic [3:0] be, input logic [31:0] res);
        b.data_req = 1'b1; b.data_we = 1'b0; b.data_addr = a; b.data_size = s;
        b.data_signed = sg; b.readdata = rd; b.waitrequest = 1'b0;
        step;
        chk("ld_read", b.read, 1); chk("ld_be", b.byteenable, be);
        chk("ld_addr", b.address, {a[31:2], 2'b00}); chk("ld_busy", b.busy, 1);
        step;
        chk("ld_read_drop", b.read, 0); chk("ld_early", b.data_done, 0);
        step;
        chk("ld_done", b.data_done, 1); chk("ld_err", b.data_err, 0); chk("ld_rdata", b.data_rdata, res);
        b.data_req = 1'b0;
        step;
        chk("ld_pulse", b.data_done, 0); chk("ld_idle", b.busy, 0);
    endtask
    task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd, input int n,
                         input logic [3:0] be, input logic [31:0] lanes);
        b.data_req = 1'b1; b.data_we = 1'b1; b.data_addr = a; b.data_size = s;
        b.data_wdata = wd; b.waitrequest = n > 0;
        step;
        chk("st_write", b.write, 1); chk("st_read", b.read, 0);
        chk("st_be", b.byteenable, be); chk("st_wd", b.writedata, lanes);
        for (int i = 0; i < n; i++) begin
            step;
            chk("st_hold", b.write, 1); chk("st_hold_wd", b.writedata, lanes); chk("st_early", b.data_done, 0);
            if (i == n - 1) b.waitrequest = 1'b0;
        end
        step;
        chk("st_write_drop", b.write, 0); chk("st_done", b.data_done, 1); chk("st_err", b.data_err, 0);
        b.data_req = 1'b0;
        step;
        chk("st_pulse", b.data_done, 0);
    endtask
    task automatic misaligned(input logic [31:0] a, input logic [1:0] s);
        b.data_req = 1'b1; b.data_we = 1'b0; b.data_addr = a; b.data_size = s;
        step;
        chk("mis_read", b.read, 0); chk("mis_done", b.data_done, 1);
        chk("mis_err", b.data_err, 1); chk("mis_busy", b.busy, 0);
        b.data_req = 1'b0;
        step;
        chk("mis_pulse", {b.data_done, b.data_err}, 0); chk("mis_keep", b.data_rdata, 32'h11223344);
    endtask
    initial begin
        b.fetch_req = 0; b.fetch_addr = 0; b.data_req = 0; b.data_we = 0; b.data_addr = 0;
        b.data_size = 0; b.data_signed = 0; b.data_wdata = 0; b.waitrequest = 0; b.readdata = 0;
        step;
        step;
        chk("rst_ctl", {b.busy, b.read, b.write, b.fetch_done, b.data_done, b.fetch_err, b.data_err}, 0);
        chk("rst_data", b.fetch_instr | b.data_rdata | b.address | b.writedata, 0);
        reset = 1'b0;
        b.fetch_req = 1'b1; b.fetch_addr = 32'hBFC00000; b.readdata = 32'h24020005;
        step;
        chk("f_read", b.read, 1); chk("f_addr", b.address, 32'hBFC00000); chk("f_be", b.byteenable, 4'hF);
        step;
        chk("f_read_drop", b.read, 0); chk("f_early", b.fetch_done, 0);
        step;
        chk("f_done", b.fetch_done, 1); chk("f_instr", b.fetch_instr, 32'h24020005); chk("f_err", b.fetch_err, 0);
        b.fetch_req = 1'b0;
        step;
        chk("f_pulse", b.fetch_done, 0);
        store(32'h1003, 2'b00, 32'h000000AB, 3, 4'b1000, 32'hABABABAB);
        store(32'h2002, 2'b01, 32'h00001234, 0, 4'b1100, 32'h12341234);
        store(32'h3000, 2'b10, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF);
        load(32'h1001, 2'b00, 1'b1, 32'h0000F300, 4'b0010, 32'hFFFFFFF3);
        load(32'h1001, 2'b00, 1'b0, 32'h0000F300, 4'b0010, 32'h000000F3);
        load(32'h1002, 2'b01, 1'b1, 32'h80010000, 4'b1100, 32'hFFFF8001);
        load(32'h1000, 2'b01, 1'b1, 32'h80017FFE, 4'b0011, 32'h00007FFE);
        b.data_req = 1'b1; b.data_we = 1'b0; b.data_addr = 32'h2000; b.data_size = 2'b10;
        b.fetch_req = 1'b1; b.fetch_addr = 32'h0; b.readdata = 32'h11223344;
        step;
        chk("pri_data_first", b.address, 32'h2000); chk("pri_read", b.read, 1);
        step;
        step;
        chk("pri_ddone", b.data_done, 1); chk("pri_fwait", b.fetch_done, 0);
        chk("pri_drdata", b.data_rdata, 32'h11223344);
        b.data_req = 1'b0; b.readdata = 32'h0BADF00D;
        step;
        chk("pri_fetch_next", b.read, 1); chk("pri_faddr", b.address, 32'h0); chk("pri_dpulse", b.data_done, 0);
        step;
        step;
        chk("pri_fdone", b.fetch_done, 1); chk("pri_finstr", b.fetch_instr, 32'h0BADF00D);
        b.fetch_req = 1'b0;
        step;
        chk("pri_fpulse", b.fetch_done, 0);
        misaligned(32'h1002, 2'b10);
        misaligned(32'h1001, 2'b01);
        misaligned(32'h1000, 2'b11);
        b.fetch_req = 1'b1; b.fetch_addr = 32'h6; b.data_req = 1'b0;
        step;
        chk("fmis_done", b.fetch_done, 1); chk("fmis_err", b.fetch_err, 1); chk("fmis_read", b.read, 0);
        b.fetch_req = 1'b0;
        step;
        b.fetch_req = 1'b1; b.fetch_addr = 32'h4; b.waitrequest = 1'b1;
        step;
        chk("to_read", b.read, 1);
        for (int i = 0; i < 7; i++) begin
            step;
            chk("to_hold", b.read, 1); chk("to_early", b.fetch_done, 0);
        end
        step;
        chk("to_drop", b.read, 0); chk("to_done", b.fetch_done, 1); chk("to_err", b.fetch_err, 1);
        chk("to_busy", b.busy, 0);
        b.fetch_req = 1'b0;
        step;
        chk("to_pulse", b.fetch_done, 0); chk("to_keep", b.fetch_instr, 32'h0BADF00D);
        b.data_req = 1'b1; b.data_we = 1'b0; b.data_addr = 32'h40; b.data_size = 2'b10;
        step;
        chk("rb_read", b.read, 1);
        step;
        reset = 1'b1;
        step;
        chk("rb_read_drop", b.read, 0); chk("rb_busy", b.busy, 0); chk("rb_done", b.data_done, 0);
        reset = 1'b0; b.data_req = 1'b0; b.waitrequest = 1'b0;
        step;
        chk("rb_idle", {b.busy, b.read, b.write}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
